trig_sched: RTL and testbench

Trigger scheduler that issues single-cycle `en` strobes to the downstream pulse stage. It sits directly upstream of that stage, which opens a 10-cycle window per `en` and raises `dout` in the window's last cycle. On `start` it emits a burst of `burst` strobes spaced exactly P cycles apart, reports progress, and signals completion. An optional minimum-gap guard keeps strobes from landing inside an open downstream window.

---
 rtl/trig_sched.sv | 157 +++++++++++++++
 tb/tb_trig_sched.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/trig_sched.sv
// Trigger scheduler: issues bursts of single-cycle en strobes spaced P cycles apart.
// Optional minimum-gap guard enabled by defining TRIG_SCHED_MIN_GAP_EN.
module trig_sched #(
    parameter int PERIOD_W = 16,
    parameter int BURST_W  = 8,
    parameter int MIN_GAP  = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                stop,
    input  logic [PERIOD_W-1:0] period,
    input  logic [BURST_W-1:0]  burst,
    output logic                en,
    output logic                busy,
    output logic                done,
    output logic [BURST_W-1:0]  remain,
    output logic                ovr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic [PERIOD_W-1:0] ONE_P = {{(PERIOD_W-1){1'b0}}, 1'b1};
    localparam logic [BURST_W-1:0]  ONE_B = {{(BURST_W-1){1'b0}}, 1'b1};

    state_t              state_r;
    logic [PERIOD_W-1:0] per_r;
    logic [PERIOD_W-1:0] gcnt_r;
    logic                fire_s;
    logic                last_s;

    // Effective strobe spacing; never zero so the gap compare below is well defined.
    function automatic logic [PERIOD_W-1:0] eff_period(input logic [PERIOD_W-1:0] p);
`ifdef TRIG_SCHED_MIN_GAP_EN
        if (p < PERIOD_W'(MIN_GAP)) begin
            return PERIOD_W'(MIN_GAP);
        end else begin
            return p;
        end
`else
        if (p == {PERIOD_W{1'b0}}) begin
            return ONE_P;
        end else begin
            return p;
        end
`endif
    endfunction

    // Decide whether the current strobe is the last one and whether the next one is due.
    always_comb begin
        fire_s = 1'b0;
        last_s = 1'b0;
        if (state_r == RUN) begin
            last_s = en && (remain == ONE_B);
            fire_s = !last_s && (gcnt_r == (per_r - ONE_P));
        end else begin
            fire_s = 1'b0;
            last_s = 1'b0;
        end
    end

    // Burst sequencer with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            per_r   <= {PERIOD_W{1'b0}};
            gcnt_r  <= {PERIOD_W{1'b0}};
            en      <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            remain  <= {BURST_W{1'b0}};
            ovr     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    en   <= 1'b0;
                    busy <= 1'b0;
                    done <= 1'b0;
                    if (start && !stop) begin
                        per_r  <= eff_period(period);
                        remain <= burst;
                        gcnt_r <= {PERIOD_W{1'b0}};
                        ovr    <= 1'b0;
                        if (burst != {BURST_W{1'b0}}) begin
                            state_r <= RUN;
                            en      <= 1'b1;
                            busy    <= 1'b1;
                        end else begin
                            state_r <= FIN;
                            done    <= 1'b1;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    if (start) begin
                        ovr <= 1'b1;
                    end else begin
                        ovr <= ovr;
                    end
                    if (stop) begin
                        // Abort also swallows a strobe that was due on this edge.
                        state_r <= IDLE;
                        en      <= 1'b0;
                        busy    <= 1'b0;
                        remain  <= {BURST_W{1'b0}};
                        gcnt_r  <= {PERIOD_W{1'b0}};
                    end else begin
                        if (en) begin
                            remain <= remain - ONE_B;
                        end else begin
                            remain <= remain;
                        end
                        if (last_s) begin
                            state_r <= FIN;
                            en      <= 1'b0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            gcnt_r  <= {PERIOD_W{1'b0}};
                        end else if (fire_s) begin
                            en     <= 1'b1;
                            gcnt_r <= {PERIOD_W{1'b0}};
                        end else begin
                            en     <= 1'b0;
                            gcnt_r <= gcnt_r + ONE_P;
                        end
                    end
                end
                FIN: begin
                    state_r <= IDLE;
                    done    <= 1'b0;
                    en      <= 1'b0;
                    busy    <= 1'b0;
                    if (start) begin
                        ovr <= 1'b1;
                    end else begin
                        ovr <= ovr;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    en      <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    remain  <= {BURST_W{1'b0}};
                    gcnt_r  <= {PERIOD_W{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trig_sched.sv
// Directed bench for trig_sched: expected strobes are queued at start and popped on each en.
module tb_trig_sched;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic [15:0] period;
    logic [7:0]  burst;
    logic        en;
    logic        busy;
    logic        done;
    logic [7:0]  remain;
    logic        ovr;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        int cyc;
        int rem;
    } strobe_t;
    strobe_t exp_q[$];

    trig_sched dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .stop   (stop),
        .period (period),
        .burst  (burst),
        .en     (en),
        .busy   (busy),
        .done   (done),
        .remain (remain),
        .ovr    (ovr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int effp(input int p);
`ifdef TRIG_SCHED_MIN_GAP_EN
        return (p < 10) ? 10 : p;
`else
        return (p == 0) ? 1 : p;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard consumer: every en must match the next queued strobe.
    always @(negedge clk) begin
        if (rst_n && en) begin
            if (exp_q.size() == 0) begin
                chk("en_unexpected", exp_q.size(), 1);
            end else begin
                strobe_t e;
                e = exp_q.pop_front();
                chk("en_cycle", cyc, e.cyc);
                chk("en_remain", remain, e.rem);
            end
        end
        if (rst_n && done) chk("done_with_busy", busy, 0);
    end

    // Start a burst in the current cycle; optionally inject an overrun start or a stop.
    task automatic run_burst(input int p, input int b, input int ovr_at, input int stop_at);
        int c, pe, last, end_t, cnt, nstb;
        int stb[$];
        bit aborted;
        c       = cyc;
        pe      = effp(p);
        aborted = (stop_at != 0);
        start   = 1'b1;
        stop    = 1'b0;
        period  = 16'(p);
        burst   = 8'(b);
        for (int k = 0; k < b; k++) begin
            if (!aborted || (c + 1 + k * pe) <= c + stop_at) begin
                strobe_t s;
                s.cyc = c + 1 + k * pe;
                s.rem = b - k;
                exp_q.push_back(s);
                stb.push_back(s.cyc);
            end
        end
        nstb  = stb.size();
        last  = (b == 0) ? c : c + 1 + (b - 1) * pe;
        end_t = aborted ? c + stop_at : last;
        for (int t = c + 1; t <= end_t + 2; t++) begin
            step();
            start = 1'b0;
            stop  = 1'b0;
            if (t == c + 1) begin
                period = 16'($urandom);
                burst  = 8'($urandom);
            end
            cnt = 0;
            for (int k = 0; k < nstb; k++) if (stb[k] < t) cnt++;
            chk("busy", busy, (t <= end_t) ? 1 : 0);
            chk("remain", remain, (t <= end_t) ? (b - cnt) : 0);
            chk("done", done, (!aborted && t == last + 1) ? 1 : 0);
            chk("ovr", ovr, (ovr_at != 0 && t > c + ovr_at) ? 1 : 0);
            if (ovr_at != 0 && t == c + ovr_at) start = 1'b1;
            if (stop_at != 0 && t == c + stop_at) stop = 1'b1;
        end
    endtask

    initial begin
        int c;
        strobe_t s;
        rst_n  = 1'b0;
        start  = 1'b0;
        stop   = 1'b0;
        period = 16'd0;
        burst  = 8'd0;
        #1;
        chk("rst_en", en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_remain", remain, 0);
        chk("rst_ovr", ovr, 0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Basic burst, clamp/no-clamp spacing, consecutive strobes with period 0.
        run_burst(20, 3, 0, 0);
        run_burst(4, 2, 0, 0);
        run_burst(0, 3, 0, 0);
        run_burst(1, 4, 0, 0);

        // Abort three cycles after the second strobe.
        run_burst(12, 5, 0, 16);
        step();
        step();

        // Overrun during RUN, then start+stop together in IDLE.
        run_burst(12, 2, 5, 0);
        start = 1'b1;
        stop  = 1'b1;
        burst = 8'd3;
        step();
        start = 1'b0;
        stop  = 1'b0;
        chk("ss_busy", busy, 0);
        chk("ss_ovr", ovr, 1);
        step();
        chk("ss_busy2", busy, 0);
        chk("ss_done", done, 0);

        // Zero-length burst: done only, clears ovr.
        run_burst(7, 0, 0, 0);

        // Reset mid-burst between strobes.
        c      = cyc;
        start  = 1'b1;
        period = 16'd20;
        burst  = 8'd3;
        s.cyc  = c + 1;
        s.rem  = 3;
        exp_q.push_back(s);
        step();
        start = 1'b0;
        repeat (5) step();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_en", en, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_remain", remain, 0);
        chk("mid_rst_ovr", ovr, 0);
        exp_q.delete();
        step();
        step();
        rst_n = 1'b1;
        run_burst(5, 1, 0, 0);
        run_burst(300, 2, 0, 0);

        step();
        chk("en_q_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
